// File: rtl/ev_pkg.sv
// Shared definitions for the EV charge-state FSM and its Increase pulse driver.
package ev_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } ev_state_t;

    localparam int EV_GAP_CYCLES = 2;
    localparam int EV_UNITS_W    = 4;
    localparam int EV_GAP_W      = 4;

endpackage

// File: rtl/ev_gap_timer.sv
// Loadable down-counter timing the idle gap between Increase pulses.
// expired flags the last cycle of the gap (count about to reach zero).
module ev_gap_timer #(
    parameter int W = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count <= W'(1));

endmodule

// File: rtl/ev_increase_driver.sv
// Turns one Start request for N units into N single-cycle Increase pulses
// separated by GAP_CYCLES idle cycles. Optional Abort input: EV_INCREASE_ABORT_EN.
module ev_increase_driver
    import ev_pkg::*;
#(
    parameter int GAP_CYCLES = EV_GAP_CYCLES,
    parameter int UNITS_W    = EV_UNITS_W
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [UNITS_W-1:0] Units,
    input  logic               Full,
`ifdef EV_INCREASE_ABORT_EN
    input  logic               Abort,
`endif
    output logic               Increase,
    output logic               Busy,
    output logic               Done,
    output logic [UNITS_W-1:0] Sent
);

    localparam logic [EV_GAP_W-1:0] GAP_LOAD = EV_GAP_W'(GAP_CYCLES);

    ev_state_t          state;
    logic [UNITS_W-1:0] remaining;
    logic               gap_load;
    logic               gap_expired;
    logic               abort_req;

`ifdef EV_INCREASE_ABORT_EN
    assign abort_req = Abort;
`else
    assign abort_req = 1'b0;
`endif

    // Reloading on every pulse is harmless; the count only matters in GAP.
    assign gap_load = (state == PULSE);

    ev_gap_timer #(
        .W(EV_GAP_W)
    ) u_gap_timer (
        .Clock  (Clock),
        .Reset  (Reset),
        .load   (gap_load),
        .value  (GAP_LOAD),
        .expired(gap_expired)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= IDLE;
            remaining <= '0;
            Sent      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        Sent <= '0;
                        if (Units != '0 && !Full) begin
                            remaining <= Units;
                            state     <= PULSE;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                PULSE: begin
                    Sent      <= Sent + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == UNITS_W'(1) || abort_req) begin
                        state <= DONE;
                    end else if (GAP_CYCLES == 0) begin
                        state <= Full ? DONE : PULSE;
                    end else begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (abort_req) begin
                        state <= DONE;
                    end else if (gap_expired) begin
                        state <= Full ? DONE : PULSE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Increase = (state == PULSE);
    assign Busy     = (state == PULSE) || (state == GAP);
    assign Done     = (state == DONE);

endmodule

// File: tb/tb_ev_increase_driver.sv
// Scoreboard bench for ev_increase_driver: one instance with the default gap,
// one with GAP_CYCLES=0. Expected Increase/Done events carry their cycle stamp.
module tb_ev_increase_driver;

    typedef struct {
        int at;
        bit is_done;
        int sent;
    } ev_t;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       a_start, b_start, a_full, b_full;
    logic [3:0] a_units, b_units;
    logic       a_inc, a_busy, a_done, b_inc, b_busy, b_done;
    logic [3:0] a_sent, b_sent;
`ifdef EV_INCREASE_ABORT_EN
    logic       a_abort = 1'b0;
    logic       b_abort = 1'b0;
`endif

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    ev_t qa[$];
    ev_t qb[$];

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    ev_increase_driver #(.GAP_CYCLES(2), .UNITS_W(4)) dut_a (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (a_start),
        .Units   (a_units),
        .Full    (a_full),
`ifdef EV_INCREASE_ABORT_EN
        .Abort   (a_abort),
`endif
        .Increase(a_inc),
        .Busy    (a_busy),
        .Done    (a_done),
        .Sent    (a_sent)
    );

    ev_increase_driver #(.GAP_CYCLES(0), .UNITS_W(4)) dut_b (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (b_start),
        .Units   (b_units),
        .Full    (b_full),
`ifdef EV_INCREASE_ABORT_EN
        .Abort   (b_abort),
`endif
        .Increase(b_inc),
        .Busy    (b_busy),
        .Done    (b_done),
        .Sent    (b_sent)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit to_b, input int at, input bit is_done, input int sent);
        ev_t e;
        e.at = at;
        e.is_done = is_done;
        e.sent = sent;
        if (to_b) qb.push_back(e);
        else qa.push_back(e);
    endtask

    task automatic observe(input string tag, input logic inc, input logic done,
                           input logic [3:0] sent, input bit is_b);
        ev_t e;
        int  n;
        if (inc !== 1'b1 && done !== 1'b1) return;
        n = is_b ? qb.size() : qa.size();
        if (n == 0) begin
            total++;
            bad++;
            $display("FAIL %s_unexpected: got inc=%b done=%b at cyc %0d, required no event",
                     tag, inc, done, cyc);
            return;
        end
        if (is_b) e = qb.pop_front();
        else e = qa.pop_front();
        check({tag, "_kind"}, {31'b0, done}, {31'b0, e.is_done});
        check({tag, "_cycle"}, cyc, e.at);
        if (e.is_done) check({tag, "_sent"}, {28'b0, sent}, e.sent);
    endtask

    // Monitor: every Increase or Done the DUTs present is matched against the queues.
    always @(negedge Clock) begin
        observe("a", a_inc, a_done, a_sent, 1'b0);
        observe("b", b_inc, b_done, b_sent, 1'b1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge Clock);
    endtask

    initial begin
        int a;
        Reset   = 1'b0;
        a_start = 1'b1; a_units = 4'd4; a_full = 1'b0;
        b_start = 1'b1; b_units = 4'd3; b_full = 1'b0;

        repeat (3) begin
            @(negedge Clock);
            check("rst_a_inc",  a_inc,  0);
            check("rst_a_busy", a_busy, 0);
            check("rst_a_done", a_done, 0);
            check("rst_a_sent", a_sent, 0);
            check("rst_b_inc",  b_inc,  0);
            check("rst_b_sent", b_sent, 0);
        end

        // Release with Start still high: 4 units, pulses every 3 cycles.
        Reset = 1'b1; b_start = 1'b0;
        a = cyc + 1;
        push(0, a, 0, 0); push(0, a + 3, 0, 0); push(0, a + 6, 0, 0); push(0, a + 9, 0, 0);
        push(0, a + 10, 1, 4);
        step(1); a_start = 1'b0;
        check("busy_first_pulse", a_busy, 1);
        step(2);
        check("busy_in_gap", a_busy, 1);
        step(9);
        check("sent_after_4", a_sent, 4);
        check("idle_busy", a_busy, 0);

        // Full raised during the second gap of a 5-unit request.
        a = cyc + 1; a_units = 4'd5; a_start = 1'b1;
        push(0, a, 0, 0); push(0, a + 3, 0, 0); push(0, a + 6, 1, 2);
        step(1); a_start = 1'b0;
        step(4); a_full = 1'b1;
        step(3); a_full = 1'b0;
        step(2);
        check("sent_full_abort", a_sent, 2);

        // Zero units: no pulse, Done next cycle.
        a = cyc + 1; a_units = 4'd0; a_start = 1'b1;
        push(0, a, 1, 0);
        step(1); a_start = 1'b0;
        step(2);

        // Start while Full: no pulse, Done next cycle.
        a = cyc + 1; a_units = 4'd3; a_full = 1'b1; a_start = 1'b1;
        push(0, a, 1, 0);
        step(1); a_start = 1'b0; a_full = 1'b0;
        step(2);

        // Start held high: ignored in PULSE/DONE, re-accepted one cycle after Done.
        a = cyc + 1; a_units = 4'd1; a_start = 1'b1;
        push(0, a, 0, 0); push(0, a + 1, 1, 1); push(0, a + 3, 0, 0); push(0, a + 4, 1, 1);
        step(4); a_start = 1'b0;
        step(3);

        // Reset during the first gap of a 4-unit request.
        a = cyc + 1; a_units = 4'd4; a_start = 1'b1;
        push(0, a, 0, 0);
        step(1); a_start = 1'b0;
        step(1); Reset = 1'b0;
        step(1); Reset = 1'b1;
        check("rst_mid_sent", a_sent, 0);
        check("rst_mid_busy", a_busy, 0);
        check("rst_mid_inc",  a_inc,  0);
        step(10);

`ifdef EV_INCREASE_ABORT_EN
        // Abort in the second gap.
        a = cyc + 1; a_units = 4'd4; a_start = 1'b1;
        push(0, a, 0, 0); push(0, a + 3, 0, 0); push(0, a + 5, 1, 2);
        step(1); a_start = 1'b0;
        step(4); a_abort = 1'b1;
        step(1); a_abort = 1'b0;
        step(3);
        check("abort_sent", a_sent, 2);
`endif

        // Zero gap: 3 consecutive pulses, Start mid-request ignored.
        a = cyc + 1; b_units = 4'd3; b_start = 1'b1;
        push(1, a, 0, 0); push(1, a + 1, 0, 0); push(1, a + 2, 0, 0); push(1, a + 3, 1, 3);
        step(1); b_start = 1'b0;
        step(1); b_start = 1'b1;
        step(1); b_start = 1'b0;
        step(3);
        check("b_sent_3", b_sent, 3);

        // Zero gap with Full at the PULSE->PULSE decision.
        a = cyc + 1; b_units = 4'd4; b_start = 1'b1;
        push(1, a, 0, 0); push(1, a + 1, 0, 0); push(1, a + 2, 1, 2);
        step(1); b_start = 1'b0;
        step(1); b_full = 1'b1;
        step(2); b_full = 1'b0;
        step(2);

        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
